// File: rtl/time_entry_loader.sv
// time_entry_loader
//   Keypad-side writer for the microwave timer digit chain. Collects decimal
//   key presses into a 4-digit BCD buffer (MM:SS), parallel-loads the buffer
//   into the BCD down-counter digits, then waits for the timer's all-zero flag.
//
//   Build option: define SEC_TENS_CHECK_EN to reject a start whose seconds-tens
//   digit exceeds 5.
//
// Parameters:
//   LOAD_CYCLES  cycles loadn is held low per load (1..7)
//
// Ports:
//   clock        in   system clock, rising edge
//   clear        in   synchronous reset, active-high
//   key_valid    in   keypad level; each rising edge is one press
//   key_code     in   [3:0] key value, 0-9 are digits
//   start        in   strobe: commit buffer to timer
//   cancel       in   strobe: abort entry or run
//   timer_zero   in   all timer digits read 0
//   load_data    out  [15:0] {min_tens, min_ones, sec_tens, sec_ones}
//   loadn        out  active-low parallel-load strobe
//   digit_count  out  [2:0] digits entered, saturating at 4
//   busy         out  high in LOAD and RUN
//   done         out  one-cycle pulse when a run reaches zero
//   entry_error  out  one-cycle pulse on a rejected key or start
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | buffer empty, waiting for the first digit
// ENTRY  | collecting digits, waiting for start/cancel
// LOAD   | loadn held low, down-counter times the strobe
// RUN    | timer counting, waiting for timer_zero/cancel
module time_entry_loader #(
    parameter int unsigned LOAD_CYCLES = 1
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        start,
    input  logic        cancel,
    input  logic        timer_zero,
    output logic [15:0] load_data,
    output logic        loadn,
    output logic [2:0]  digit_count,
    output logic        busy,
    output logic        done,
    output logic        entry_error
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ENTRY = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    // Down-counter reload: terminal count 0 marks the last low cycle of loadn.
    localparam logic [2:0] LOAD_RELOAD = 3'(LOAD_CYCLES - 1);

    logic [1:0]  state_q,       state_d;
    logic [15:0] buf_q,         buf_d;
    logic [2:0]  count_q,       count_d;
    logic [2:0]  load_cnt_q,    load_cnt_d;
    logic        loadn_q,       loadn_d;
    logic        done_q,        done_d;
    logic        err_q,         err_d;
    logic        key_prev_q,    key_prev_d;

    logic        key_press;
    logic        key_is_digit;
    logic [15:0] buf_shifted;
    logic [2:0]  count_inc;

    assign key_press    = key_valid & ~key_prev_q;
    assign key_is_digit = (key_code <= 4'd9);
    // Oldest digit (min_tens) falls off the top on a fifth entry.
    assign buf_shifted  = {buf_q[11:0], key_code};
    assign count_inc    = (count_q == 3'd4) ? 3'd4 : count_q + 3'd1;

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        count_d    = count_q;
        load_cnt_d = load_cnt_q;
        loadn_d    = loadn_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        key_prev_d = key_valid;

        case (state_q)
            ST_IDLE: begin
                if (key_press) begin
                    if (key_is_digit) begin
                        buf_d   = buf_shifted;
                        count_d = count_inc;
                        state_d = ST_ENTRY;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ENTRY: begin
                if (cancel) begin
                    buf_d   = 16'h0000;
                    count_d = 3'd0;
                    state_d = ST_IDLE;
                end else if (start) begin
                    // A key press coinciding with start is dropped.
`ifdef SEC_TENS_CHECK_EN
                    if (buf_q[7:4] > 4'd5) begin
                        err_d = 1'b1;
                    end else begin
                        loadn_d    = 1'b0;
                        load_cnt_d = LOAD_RELOAD;
                        state_d    = ST_LOAD;
                    end
`else
                    loadn_d    = 1'b0;
                    load_cnt_d = LOAD_RELOAD;
                    state_d    = ST_LOAD;
`endif
                end else if (key_press) begin
                    if (key_is_digit) begin
                        buf_d   = buf_shifted;
                        count_d = count_inc;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (cancel) begin
                    loadn_d = 1'b1;
                    buf_d   = 16'h0000;
                    count_d = 3'd0;
                    state_d = ST_IDLE;
                end else if (load_cnt_q == 3'd0) begin
                    loadn_d = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    load_cnt_d = load_cnt_q - 3'd1;
                end
            end
            ST_RUN: begin
                // cancel outranks timer_zero so a simultaneous pair never pulses done.
                if (cancel || timer_zero) begin
                    done_d  = ~cancel;
                    buf_d   = 16'h0000;
                    count_d = 3'd0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q    <= ST_IDLE;
            buf_q      <= 16'h0000;
            count_q    <= 3'd0;
            load_cnt_q <= 3'd0;
            loadn_q    <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            key_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            count_q    <= count_d;
            load_cnt_q <= load_cnt_d;
            loadn_q    <= loadn_d;
            done_q     <= done_d;
            err_q      <= err_d;
            key_prev_q <= key_prev_d;
        end
    end

    assign load_data   = buf_q;
    assign loadn       = loadn_q;
    assign digit_count = count_q;
    assign busy        = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign done        = done_q;
    assign entry_error = err_q;

endmodule

// File: tb/tb_time_entry_loader.sv
module tb_time_entry_loader;

    localparam int K_LOAD = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    logic        clock = 1'b0;
    logic        clear;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        start;
    logic        cancel;
    logic        timer_zero;
    logic [15:0] load_data;
    logic        loadn;
    logic [2:0]  digit_count;
    logic        busy;
    logic        done;
    logic        entry_error;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        int          kind;
        logic [15:0] data;
        logic [2:0]  cnt;
    } exp_t;

    exp_t sb_q[$];

    time_entry_loader #(.LOAD_CYCLES(1)) dut (
        .clock       (clock),
        .clear       (clear),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .start       (start),
        .cancel      (cancel),
        .timer_zero  (timer_zero),
        .load_data   (load_data),
        .loadn       (loadn),
        .digit_count (digit_count),
        .busy        (busy),
        .done        (done),
        .entry_error (entry_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic expect_ev(input int kind, input logic [15:0] data, input logic [2:0] cnt);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.cnt  = cnt;
        sb_q.push_back(e);
    endtask

    task automatic mon_event(input int kind);
        exp_t e;
        if (sb_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_event: got kind %0d expected none", kind);
        end else begin
            e = sb_q.pop_front();
            check("event_kind", kind, e.kind);
            if (kind == e.kind) begin
                case (kind)
                    K_LOAD: begin
                        check("load_data_on_load", {16'h0, load_data}, {16'h0, e.data});
                        check("busy_on_load", {31'h0, busy}, 32'd1);
                    end
                    K_DONE: begin
                        check("busy_on_done", {31'h0, busy}, 32'd0);
                        check("load_data_on_done", {16'h0, load_data}, 32'h0);
                        check("digit_count_on_done", {29'h0, digit_count}, 32'd0);
                    end
                    default: begin
                        check("load_data_on_err", {16'h0, load_data}, {16'h0, e.data});
                        check("digit_count_on_err", {29'h0, digit_count}, {29'h0, e.cnt});
                    end
                endcase
            end
        end
    endtask

    // Monitor: every cycle the DUT shows loadn low, done or entry_error, the
    // oldest scoreboard entry must describe it.
    always @(negedge clock) begin
        if (!clear) begin
            if (loadn === 1'b0)      mon_event(K_LOAD);
            if (done === 1'b1)       mon_event(K_DONE);
            if (entry_error === 1'b1) mon_event(K_ERR);
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [3:0] code);
        key_code  = code;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        tick();
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_cancel;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    task automatic check_state(input string name, input logic [15:0] data, input logic [2:0] cnt,
                               input logic b);
        check({name, "_data"},  {16'h0, load_data},   {16'h0, data});
        check({name, "_count"}, {29'h0, digit_count}, {29'h0, cnt});
        check({name, "_busy"},  {31'h0, busy},        {31'h0, b});
    endtask

    initial begin
        clear      = 1'b1;
        key_valid  = 1'b0;
        key_code   = 4'd0;
        start      = 1'b0;
        cancel     = 1'b0;
        timer_zero = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            key_valid  = 1'($urandom_range(0, 1));
            key_code   = 4'($urandom_range(0, 15));
            start      = 1'($urandom_range(0, 1));
            cancel     = 1'($urandom_range(0, 1));
            timer_zero = 1'($urandom_range(0, 1));
            tick();
        end
        key_valid = 1'b0; start = 1'b0; cancel = 1'b0; timer_zero = 1'b0;
        check_state("reset", 16'h0000, 3'd0, 1'b0);
        check("reset_loadn", {31'h0, loadn}, 32'd1);
        check("reset_done", {31'h0, done}, 32'd0);
        check("reset_err", {31'h0, entry_error}, 32'd0);
        clear = 1'b0;
        tick();

        // 1,3,0 then start, then timer_zero
        press(4'd1); press(4'd3); press(4'd0);
        check_state("entry_130", 16'h0130, 3'd3, 1'b0);
        expect_ev(K_LOAD, 16'h0130, 3'd3);
        pulse_start();
        check("busy_in_load", {31'h0, busy}, 32'd1);
        tick();
        check("loadn_in_run", {31'h0, loadn}, 32'd1);
        check_state("run_130", 16'h0130, 3'd3, 1'b1);
        tick();
        expect_ev(K_DONE, 16'h0000, 3'd0);
        timer_zero = 1'b1;
        tick();
        timer_zero = 1'b0;
        check_state("after_done", 16'h0000, 3'd0, 1'b0);
        tick(); tick();

        // Five digits wrap; held key counts once
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
        check_state("wrap_2345", 16'h2345, 3'd4, 1'b0);
        key_code  = 4'd7;
        key_valid = 1'b1;
        repeat (10) tick();
        key_valid = 1'b0;
        tick();
        check_state("held_key", 16'h3457, 3'd4, 1'b0);

        // Bad code in ENTRY, then cancel, then bad code in IDLE
        expect_ev(K_ERR, 16'h3457, 3'd4);
        press(4'd12);
        check_state("err_entry", 16'h3457, 3'd4, 1'b0);
        pulse_cancel();
        check_state("cancel_entry", 16'h0000, 3'd0, 1'b0);
        expect_ev(K_ERR, 16'h0000, 3'd0);
        press(4'd12);
        check_state("err_idle", 16'h0000, 3'd0, 1'b0);
        pulse_start();
        tick();
        check_state("start_idle_ignored", 16'h0000, 3'd0, 1'b0);

        // start+cancel in ENTRY: cancel wins, loadn never low
        press(4'd5);
        check_state("entry_5", 16'h0005, 3'd1, 1'b0);
        start = 1'b1; cancel = 1'b1;
        tick();
        start = 1'b0; cancel = 1'b0;
        tick(); tick();
        check_state("start_cancel", 16'h0000, 3'd0, 1'b0);

        // cancel+timer_zero in RUN: no done
        press(4'd4); press(4'd2);
        expect_ev(K_LOAD, 16'h0042, 3'd2);
        pulse_start();
        tick(); tick();
        check_state("run_42", 16'h0042, 3'd2, 1'b1);
        cancel = 1'b1; timer_zero = 1'b1;
        tick();
        cancel = 1'b0; timer_zero = 1'b0;
        tick();
        check_state("run_cancel", 16'h0000, 3'd0, 1'b0);

        // cancel during LOAD
        press(4'd9);
        expect_ev(K_LOAD, 16'h0009, 3'd1);
        pulse_start();
        pulse_cancel();
        tick();
        check_state("load_cancel", 16'h0000, 3'd0, 1'b0);
        check("load_cancel_loadn", {31'h0, loadn}, 32'd1);

        // All-zero commit with timer_zero already high: done on first RUN cycle
        press(4'd0);
        expect_ev(K_LOAD, 16'h0000, 3'd1);
        expect_ev(K_DONE, 16'h0000, 3'd0);
        timer_zero = 1'b1;
        pulse_start();
        tick();
        tick();
        timer_zero = 1'b0;
        tick(); tick();
        check_state("zero_commit", 16'h0000, 3'd0, 1'b0);

        // seconds-tens digit 7
        press(4'd0); press(4'd7); press(4'd0);
        check_state("entry_070", 16'h0070, 3'd3, 1'b0);
`ifdef SEC_TENS_CHECK_EN
        expect_ev(K_ERR, 16'h0070, 3'd3);
        pulse_start();
        tick();
        check_state("sec_tens_reject", 16'h0070, 3'd3, 1'b0);
        check("sec_tens_loadn", {31'h0, loadn}, 32'd1);
        pulse_cancel();
`else
        expect_ev(K_LOAD, 16'h0070, 3'd3);
        pulse_start();
        tick(); tick();
        check_state("sec_tens_run", 16'h0070, 3'd3, 1'b1);
        expect_ev(K_DONE, 16'h0000, 3'd0);
        timer_zero = 1'b1;
        tick();
        timer_zero = 1'b0;
`endif
        tick(); tick(); tick();
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
